// File: rtl/j11_pkg.sv
// Shared definitions for the J11 DMA arbiter: bus widths, FSM encoding
// and a one-hot to index helper.
package j11_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Convert a one-hot vector (up to 8 requesters) to a binary index.
    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/j11_dma_arb_if.sv
// Requester-side and downstream-side signals of the J11 DMA arbiter.
// The arbiter uses the master modport; the surrounding system uses slave.
interface j11_dma_arb_if #(
    parameter int NREQ = 4
);
    import j11_pkg::*;

    // requester side
    logic [NREQ-1:0]        mreq;
    logic [NREQ-1:0]        mwr;
    logic [ADDR_W*NREQ-1:0] maddr;
    logic [DATA_W*NREQ-1:0] mwdata;
    logic [NREQ-1:0]        mack;
    logic [DATA_W-1:0]      mrdata;
    logic                   merr;
    logic [NREQ-1:0]        gnt;

    // downstream side
    logic                   dreq;
    logic                   dwr;
    logic [ADDR_W-1:0]      daddr;
    logic [DATA_W-1:0]      dwdata;
    logic                   dack;
    logic [DATA_W-1:0]      drdata;
    logic                   derr;

    modport master (
        input  mreq, mwr, maddr, mwdata, dack, drdata, derr,
        output mack, mrdata, merr, gnt, dreq, dwr, daddr, dwdata
    );

    modport slave (
        output mreq, mwr, maddr, mwdata, dack, drdata, derr,
        input  mack, mrdata, merr, gnt, dreq, dwr, daddr, dwdata
    );

endinterface

// File: rtl/j11_rr_pick.sv
// Combinational round-robin picker: first set pend bit at or above rrptr,
// wrapping to the lowest set bit when nothing at or above rrptr is pending.
module j11_rr_pick #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  pend,
    input  logic [IDX_W-1:0] rrptr,
    output logic             valid,
    output logic [NREQ-1:0]  grant
);

    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] masked;

    // Lowest set bit of the masked vector, else lowest set bit overall.
    always_comb begin
        mask   = {NREQ{1'b1}} << rrptr;
        masked = pend & mask;
        valid  = |pend;
        if (|masked) begin
            grant = masked & (~masked + 1'b1);
        end else begin
            grant = pend & (~pend + 1'b1);
        end
    end

endmodule

// File: rtl/j11_dma_arb.sv
// J11 DMA arbiter: captures per-requester single-cycle requests, grants them
// round-robin onto one downstream port and returns a completion pulse.
// Optional feature macro: J11_DMA_ARB_TIMEOUT_EN (abort when dack never comes).
module j11_dma_arb
    import j11_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    j11_dma_arb_if.master    bus
);

    localparam int IDX_W = $clog2(NREQ);

    state_t              state_q, state_d;
    logic [NREQ-1:0]     pend_q, pend_d;
    logic [IDX_W-1:0]    rrptr_q, rrptr_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     mack_q, mack_d;
    logic                dreq_q, dreq_d;
    logic [DATA_W-1:0]   mrdata_q, mrdata_d;
    logic                merr_q, merr_d;
    logic                dwr_q, dwr_d;
    logic [ADDR_W-1:0]   daddr_q, daddr_d;
    logic [DATA_W-1:0]   dwdata_q, dwdata_d;

    // captured request fields, one slot per requester
    logic                cap_wr_q   [NREQ];
    logic                cap_wr_d   [NREQ];
    logic [ADDR_W-1:0]   cap_addr_q [NREQ];
    logic [ADDR_W-1:0]   cap_addr_d [NREQ];
    logic [DATA_W-1:0]   cap_data_q [NREQ];
    logic [DATA_W-1:0]   cap_data_d [NREQ];

    logic [NREQ-1:0]     cap_en;
    logic [NREQ-1:0]     grant_now;
    logic                pick_valid;
    logic [NREQ-1:0]     pick_gnt;
    logic [7:0]          pick_gnt_pad;
    logic [IDX_W-1:0]    pick_idx;

`ifdef J11_DMA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;
`endif

    j11_rr_pick #(.NREQ(NREQ)) u_pick (
        .pend  (pend_q),
        .rrptr (rrptr_q),
        .valid (pick_valid),
        .grant (pick_gnt)
    );

    // Binary index of the picked requester.
    always_comb begin
        pick_gnt_pad             = '0;
        pick_gnt_pad[NREQ-1:0]   = pick_gnt;
        pick_idx                 = IDX_W'(oh2idx(pick_gnt_pad));
    end

    // Field capture: a new request loads its slot unless one is already
    // pending; the slot being granted this cycle is free again.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cap
        assign cap_wr_d[gi]   = cap_en[gi] ? bus.mwr[gi] : cap_wr_q[gi];
        assign cap_addr_d[gi] = cap_en[gi] ? bus.maddr[ADDR_W*gi +: ADDR_W]
                                           : cap_addr_q[gi];
        assign cap_data_d[gi] = cap_en[gi] ? bus.mwdata[DATA_W*gi +: DATA_W]
                                           : cap_data_q[gi];
    end

    // Next-state, grant and completion logic.
    always_comb begin
        state_d   = state_q;
        rrptr_d   = rrptr_q;
        gnt_d     = gnt_q;
        mack_d    = '0;
        dreq_d    = 1'b0;
        mrdata_d  = mrdata_q;
        merr_d    = merr_q;
        dwr_d     = dwr_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        grant_now = '0;
`ifdef J11_DMA_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = BUSY;
                    grant_now = pick_gnt;
                    gnt_d     = pick_gnt;
                    dreq_d    = 1'b1;
                    dwr_d     = cap_wr_q[pick_idx];
                    daddr_d   = cap_addr_q[pick_idx];
                    dwdata_d  = cap_data_q[pick_idx];
                    rrptr_d   = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
`ifdef J11_DMA_ARB_TIMEOUT_EN
                    cnt_d     = CNT_W'(TIMEOUT);
`endif
                end
            end
            BUSY: begin
                // dack in the dreq cycle belongs to nothing and is dropped
                if (bus.dack && !dreq_q) begin
                    mack_d   = gnt_q;
                    mrdata_d = bus.drdata;
                    merr_d   = bus.derr;
                    gnt_d    = '0;
                    state_d  = IDLE;
                end
`ifdef J11_DMA_ARB_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    mack_d   = gnt_q;
                    mrdata_d = '0;
                    merr_d   = 1'b1;
                    gnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // set beats clear when a requester re-requests as it is granted
        cap_en = bus.mreq & (~pend_q | grant_now);
        pend_d = (pend_q & ~grant_now) | cap_en;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            rrptr_q  <= '0;
            gnt_q    <= '0;
            mack_q   <= '0;
            dreq_q   <= 1'b0;
            mrdata_q <= '0;
            merr_q   <= 1'b0;
            dwr_q    <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
`ifdef J11_DMA_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
            for (int i = 0; i < NREQ; i++) begin
                cap_wr_q[i]   <= 1'b0;
                cap_addr_q[i] <= '0;
                cap_data_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            rrptr_q  <= rrptr_d;
            gnt_q    <= gnt_d;
            mack_q   <= mack_d;
            dreq_q   <= dreq_d;
            mrdata_q <= mrdata_d;
            merr_q   <= merr_d;
            dwr_q    <= dwr_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
`ifdef J11_DMA_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
            for (int i = 0; i < NREQ; i++) begin
                cap_wr_q[i]   <= cap_wr_d[i];
                cap_addr_q[i] <= cap_addr_d[i];
                cap_data_q[i] <= cap_data_d[i];
            end
        end
    end

    assign bus.mack   = mack_q;
    assign bus.mrdata = mrdata_q;
    assign bus.merr   = merr_q;
    assign bus.gnt    = gnt_q;
    assign bus.dreq   = dreq_q;
    assign bus.dwr    = dwr_q;
    assign bus.daddr  = daddr_q;
    assign bus.dwdata = dwdata_q;

endmodule

// File: tb/tb_j11_dma_arb.sv
// Directed testbench for j11_dma_arb (NREQ=4). Built with or without
// J11_DMA_ARB_TIMEOUT_EN; the timeout scenario follows the macro.
module tb_j11_dma_arb;
    import j11_pkg::*;

    localparam int NREQ = 4;
`ifdef J11_DMA_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    j11_dma_arb_if #(.NREQ(NREQ)) bus ();

    j11_dma_arb #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [17:0] a, input logic [15:0] d);
        bus.mreq[i]              = 1'b1;
        bus.mwr[i]               = wr;
        bus.maddr[18*i +: 18]    = a;
        bus.mwdata[16*i +: 16]   = d;
    endtask

    task automatic clr_req;
        bus.mreq = '0;
    endtask

    // ticks until dreq is seen; n = ticks taken, or -1 if budget expired
    task automatic wait_dreq(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            tick;
            if (bus.dreq) begin
                n = k;
                break;
            end
        end
    endtask

    // from a BUSY cycle: dack for one cycle, return in the mack cycle
    task automatic ack(input logic [15:0] rd, input logic err);
        tick;
        bus.dack   = 1'b1;
        bus.drdata = rd;
        bus.derr   = err;
        tick;
        bus.dack   = 1'b0;
        bus.derr   = 1'b0;
        $display("txn: mack=%b mrdata=%h merr=%b", bus.mack, bus.mrdata, bus.merr);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        total++; if (bus.mack !== 4'b0000) begin bad++; $display("FAIL reset_mack: got %b want 0000", bus.mack); end
        total++; if (bus.dreq !== 1'b0) begin bad++; $display("FAIL reset_dreq: got %b want 0", bus.dreq); end
        total++; if (bus.mrdata !== 16'h0) begin bad++; $display("FAIL reset_mrdata: got %h want 0000", bus.mrdata); end
        total++; if (bus.merr !== 1'b0) begin bad++; $display("FAIL reset_merr: got %b want 0", bus.merr); end
        total++; if (bus.daddr !== 18'h0) begin bad++; $display("FAIL reset_daddr: got %o want 0", bus.daddr); end
        total++; if (bus.dwdata !== 16'h0) begin bad++; $display("FAIL reset_dwdata: got %h want 0", bus.dwdata); end
        total++; if (bus.dwr !== 1'b0) begin bad++; $display("FAIL reset_dwr: got %b want 0", bus.dwr); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        set_req(1, 1'b0, 18'o777000, 16'h0);
        tick;
        clr_req;
        total++; if (bus.dreq !== 1'b0) begin bad++; $display("FAIL single_dreq_t1: got %b want 0", bus.dreq); end
        tick;
        total++; if (bus.dreq !== 1'b1) begin bad++; $display("FAIL single_dreq_t2: got %b want 1", bus.dreq); end
        total++; if (bus.daddr !== 18'o777000) begin bad++; $display("FAIL single_daddr: got %o want 777000", bus.daddr); end
        total++; if (bus.dwr !== 1'b0) begin bad++; $display("FAIL single_dwr: got %b want 0", bus.dwr); end
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL single_gnt: got %b want 0010", bus.gnt); end
        ack(16'o123456, 1'b0);
        total++; if (bus.mack !== 4'b0010) begin bad++; $display("FAIL single_mack: got %b want 0010", bus.mack); end
        total++; if (bus.mrdata !== 16'o123456) begin bad++; $display("FAIL single_mrdata: got %o want 123456", bus.mrdata); end
        total++; if (bus.merr !== 1'b0) begin bad++; $display("FAIL single_merr: got %b want 0", bus.merr); end
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL single_gnt_clr: got %b want 0000", bus.gnt); end
        tick;
        total++; if (bus.mack !== 4'b0000) begin bad++; $display("FAIL single_mack_pulse: got %b want 0000", bus.mack); end
        total++; if (bus.mrdata !== 16'o123456) begin bad++; $display("FAIL single_mrdata_hold: got %o want 123456", bus.mrdata); end
    endtask

    task automatic test_dack_ignored;
        // dack while idle
        bus.dack   = 1'b1;
        bus.drdata = 16'hDEAD;
        tick;
        bus.dack   = 1'b0;
        tick;
        total++; if (bus.mack !== 4'b0000) begin bad++; $display("FAIL idle_dack_mack: got %b want 0000", bus.mack); end
        total++; if (bus.mrdata !== 16'o123456) begin bad++; $display("FAIL idle_dack_mrdata: got %h want %h", bus.mrdata, 16'o123456); end
        // dack in the dreq cycle
        set_req(3, 1'b0, 18'o1234, 16'h0);
        tick;
        clr_req;
        tick;
        total++; if (bus.dreq !== 1'b1) begin bad++; $display("FAIL early_dack_dreq: got %b want 1", bus.dreq); end
        bus.dack   = 1'b1;
        bus.drdata = 16'hAAAA;
        tick;
        bus.dack   = 1'b0;
        tick;
        total++; if (bus.mack !== 4'b0000) begin bad++; $display("FAIL early_dack_mack: got %b want 0000", bus.mack); end
        total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL early_dack_gnt: got %b want 1000", bus.gnt); end
        ack(16'h3C3C, 1'b0);
        total++; if (bus.mack !== 4'b1000) begin bad++; $display("FAIL early_dack_final_mack: got %b want 1000", bus.mack); end
        total++; if (bus.mrdata !== 16'h3C3C) begin bad++; $display("FAIL early_dack_final_mrdata: got %h want 3c3c", bus.mrdata); end
    endtask

    task automatic test_fairness;
        int          n;
        int          order   [5];
        logic [17:0] expaddr [5];
        order   = '{0, 1, 2, 3, 0};
        expaddr = '{18'o1000, 18'o1001, 18'o1002, 18'o1003, 18'o2000};
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b0, 18'o1000 + 18'(i), 16'h0);
        end
        tick;
        clr_req;
        for (int k = 0; k < 5; k++) begin
            wait_dreq(8, n);
            total++; if (n !== 1) begin bad++; $display("FAIL fair_latency[%0d]: got %0d cycles want 1", k, n); end
            total++; if (bus.gnt !== 4'(1 << order[k])) begin bad++; $display("FAIL fair_gnt[%0d]: got %b want %b", k, bus.gnt, 4'(1 << order[k])); end
            total++; if (bus.daddr !== expaddr[k]) begin bad++; $display("FAIL fair_daddr[%0d]: got %o want %o", k, bus.daddr, expaddr[k]); end
            if (k == 0) begin
                set_req(0, 1'b0, 18'o2000, 16'h0);
            end
            tick;
            clr_req;
            bus.dack   = 1'b1;
            bus.drdata = 16'(k + 16'h100);
            tick;
            bus.dack   = 1'b0;
            $display("txn: fair k=%0d mack=%b mrdata=%h", k, bus.mack, bus.mrdata);
            total++; if (bus.mack !== 4'(1 << order[k])) begin bad++; $display("FAIL fair_mack[%0d]: got %b want %b", k, bus.mack, 4'(1 << order[k])); end
            total++; if (bus.mrdata !== 16'(k + 16'h100)) begin bad++; $display("FAIL fair_mrdata[%0d]: got %h want %h", k, bus.mrdata, 16'(k + 16'h100)); end
        end
        wait_dreq(6, n);
        total++; if (n !== -1) begin bad++; $display("FAIL fair_drain: got dreq after %0d cycles want none", n); end
    endtask

    task automatic test_error;
        int n;
        set_req(2, 1'b1, 18'o000100, 16'hBEEF);
        tick;
        clr_req;
        wait_dreq(8, n);
        total++; if (n !== 1) begin bad++; $display("FAIL err_latency: got %0d want 1", n); end
        total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL err_gnt: got %b want 0100", bus.gnt); end
        total++; if (bus.dwr !== 1'b1) begin bad++; $display("FAIL err_dwr: got %b want 1", bus.dwr); end
        total++; if (bus.dwdata !== 16'hBEEF) begin bad++; $display("FAIL err_dwdata: got %h want beef", bus.dwdata); end
        total++; if (bus.daddr !== 18'o000100) begin bad++; $display("FAIL err_daddr: got %o want 100", bus.daddr); end
        ack(16'h5555, 1'b1);
        total++; if (bus.mack !== 4'b0100) begin bad++; $display("FAIL err_mack: got %b want 0100", bus.mack); end
        total++; if (bus.merr !== 1'b1) begin bad++; $display("FAIL err_merr: got %b want 1", bus.merr); end
        total++; if (bus.mrdata !== 16'h5555) begin bad++; $display("FAIL err_mrdata: got %h want 5555", bus.mrdata); end
    endtask

    task automatic test_duplicate;
        int n;
        set_req(3, 1'b0, 18'o3333, 16'h0);
        tick;
        clr_req;
        wait_dreq(8, n);
        set_req(0, 1'b0, 18'o4000, 16'h0);
        tick;
        set_req(0, 1'b0, 18'o5000, 16'h0);
        tick;
        clr_req;
        bus.dack   = 1'b1;
        bus.drdata = 16'h0303;
        tick;
        bus.dack   = 1'b0;
        total++; if (bus.mack !== 4'b1000) begin bad++; $display("FAIL dup_mack3: got %b want 1000", bus.mack); end
        total++; if (bus.merr !== 1'b0) begin bad++; $display("FAIL dup_merr: got %b want 0", bus.merr); end
        wait_dreq(8, n);
        total++; if (n !== 1) begin bad++; $display("FAIL dup_latency: got %0d want 1", n); end
        total++; if (bus.daddr !== 18'o4000) begin bad++; $display("FAIL dup_daddr: got %o want 4000", bus.daddr); end
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL dup_gnt: got %b want 0001", bus.gnt); end
        ack(16'h0000, 1'b0);
        total++; if (bus.mack !== 4'b0001) begin bad++; $display("FAIL dup_mack0: got %b want 0001", bus.mack); end
        wait_dreq(6, n);
        total++; if (n !== -1) begin bad++; $display("FAIL dup_no_second: got dreq after %0d cycles want none", n); end
    endtask

    task automatic test_coincide;
        int n;
        set_req(3, 1'b0, 18'o6000, 16'h0);
        tick;
        clr_req;
        wait_dreq(8, n);
        set_req(0, 1'b0, 18'o6100, 16'h0);
        tick;
        clr_req;
        bus.dack = 1'b1;
        tick;
        bus.dack = 1'b0;
        total++; if (bus.mack !== 4'b1000) begin bad++; $display("FAIL coin_mack3: got %b want 1000", bus.mack); end
        set_req(0, 1'b0, 18'o6200, 16'h0);
        tick;
        clr_req;
        total++; if (bus.dreq !== 1'b1) begin bad++; $display("FAIL coin_dreq1: got %b want 1", bus.dreq); end
        total++; if (bus.daddr !== 18'o6100) begin bad++; $display("FAIL coin_daddr_old: got %o want 6100", bus.daddr); end
        ack(16'h1212, 1'b0);
        total++; if (bus.mack !== 4'b0001) begin bad++; $display("FAIL coin_mack0a: got %b want 0001", bus.mack); end
        wait_dreq(4, n);
        total++; if (n !== 1) begin bad++; $display("FAIL coin_latency: got %0d want 1", n); end
        total++; if (bus.daddr !== 18'o6200) begin bad++; $display("FAIL coin_daddr_new: got %o want 6200", bus.daddr); end
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL coin_gnt: got %b want 0001", bus.gnt); end
        ack(16'h7777, 1'b0);
        total++; if (bus.mack !== 4'b0001) begin bad++; $display("FAIL coin_mack0b: got %b want 0001", bus.mack); end
        total++; if (bus.mrdata !== 16'h7777) begin bad++; $display("FAIL coin_mrdata: got %h want 7777", bus.mrdata); end
    endtask

`ifdef J11_DMA_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        int hit;
        set_req(1, 1'b0, 18'o7200, 16'h0);
        tick;
        clr_req;
        wait_dreq(8, n);
        total++; if (n !== 1) begin bad++; $display("FAIL to_latency: got %0d want 1", n); end
        hit = -1;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (bus.mack !== 4'b0000) begin
                hit = c;
                break;
            end
        end
        $display("txn: timeout mack=%b mrdata=%h merr=%b", bus.mack, bus.mrdata, bus.merr);
        total++; if (hit !== 9) begin bad++; $display("FAIL to_delay: got %0d cycles after dreq want 9", hit); end
        total++; if (bus.mack !== 4'b0010) begin bad++; $display("FAIL to_mack: got %b want 0010", bus.mack); end
        total++; if (bus.merr !== 1'b1) begin bad++; $display("FAIL to_merr: got %b want 1", bus.merr); end
        total++; if (bus.mrdata !== 16'h0) begin bad++; $display("FAIL to_mrdata: got %h want 0000", bus.mrdata); end
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL to_gnt: got %b want 0000", bus.gnt); end
        bus.dack   = 1'b1;
        bus.drdata = 16'h1111;
        tick;
        bus.dack   = 1'b0;
        tick;
        total++; if (bus.mack !== 4'b0000) begin bad++; $display("FAIL to_late_mack: got %b want 0000", bus.mack); end
        total++; if (bus.mrdata !== 16'h0) begin bad++; $display("FAIL to_late_mrdata: got %h want 0000", bus.mrdata); end
    endtask
`else
    task automatic test_timeout;
        int n;
        int seen;
        set_req(1, 1'b0, 18'o7200, 16'h0);
        tick;
        clr_req;
        wait_dreq(8, n);
        total++; if (n !== 1) begin bad++; $display("FAIL nto_latency: got %0d want 1", n); end
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            tick;
            if (bus.mack !== 4'b0000) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL nto_no_mack: got %0d pulses want 0", seen); end
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL nto_gnt: got %b want 0010", bus.gnt); end
        ack(16'h2222, 1'b0);
        total++; if (bus.mack !== 4'b0010) begin bad++; $display("FAIL nto_mack: got %b want 0010", bus.mack); end
        total++; if (bus.mrdata !== 16'h2222) begin bad++; $display("FAIL nto_mrdata: got %h want 2222", bus.mrdata); end
    endtask
`endif

    task automatic test_reset_mid;
        int n;
        set_req(1, 1'b0, 18'o7000, 16'h0);
        tick;
        clr_req;
        wait_dreq(8, n);
        set_req(2, 1'b0, 18'o7100, 16'h0);
        tick;
        clr_req;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.dack   = 1'b1;
        bus.drdata = 16'hFFFF;
        tick;
        bus.dack   = 1'b0;
        total++; if (bus.mack !== 4'b0000) begin bad++; $display("FAIL rmid_mack: got %b want 0000", bus.mack); end
        total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rmid_gnt: got %b want 0000", bus.gnt); end
        total++; if (bus.mrdata !== 16'h0) begin bad++; $display("FAIL rmid_mrdata: got %h want 0000", bus.mrdata); end
        wait_dreq(6, n);
        total++; if (n !== -1) begin bad++; $display("FAIL rmid_pend: got dreq after %0d cycles want none", n); end
    endtask

    initial begin
        rst         = 1'b1;
        bus.mreq    = '0;
        bus.mwr     = '0;
        bus.maddr   = '0;
        bus.mwdata  = '0;
        bus.dack    = 1'b0;
        bus.drdata  = '0;
        bus.derr    = 1'b0;
        test_reset;
        test_single;
        test_dack_ignored;
        test_fairness;
        test_error;
        test_duplicate;
        test_coincide;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/j11_dma_arb.md
J11_DMA_ARB -- requirements
Module: j11_dma_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, giving the number of DMA requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the cycles to wait for dack before aborting (used only with J11_DMA_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mreq, input, NREQ bits: per-requester single-cycle request pulse.
REQ-006 SHALL have port mwr, input, NREQ bits: per-requester write flag, sampled with mreq.
REQ-007 SHALL have port maddr, input, 18*NREQ bits: unibus addresses; requester i uses slice [18i+17:18i].
REQ-008 SHALL have port mwdata, input, 16*NREQ bits: write data; requester i uses slice [16i+15:16i].
REQ-009 SHALL have port mack, output, NREQ bits: per-requester single-cycle completion pulse.
REQ-010 SHALL have port mrdata, output, 16 bits: read data shared by all requesters, valid with any mack bit.
REQ-011 SHALL have port merr, output, 1 bit: error flag shared by all requesters, valid with any mack bit.
REQ-012 SHALL have port gnt, output, NREQ bits: one-hot in-flight owner; all zero when idle.
REQ-013 SHALL have port dreq, output, 1 bit: downstream single-cycle request pulse.
REQ-014 SHALL have ports dwr (1 bit), daddr (18 bits) and dwdata (16 bits), outputs: downstream write flag, address and data, stable from dreq until dack.
REQ-015 SHALL have ports dack (1 bit), drdata (16 bits) and derr (1 bit), inputs: downstream completion, read data and error.

Function
REQ-016 SHALL set pend[i], and capture mwr/maddr/mwdata slice i, on any cycle in which mreq[i] is high and pend[i] is low; an mreq[i] while pend[i] is already set SHALL be ignored, with no field overwrite.
REQ-017 SHALL implement states IDLE and BUSY, where IDLE goes to BUSY when any pend bit is set, and BUSY goes to IDLE on dack (or on timeout).
REQ-018 SHALL grant in IDLE the first set pend bit at or after rrptr, searching upward modulo NREQ; at that edge it SHALL load dwr/daddr/dwdata, set gnt, clear pend[g] and set rrptr to (g+1) mod NREQ.
REQ-019 SHALL assert dreq for exactly one cycle, in the first BUSY cycle; an mreq pulse at cycle t on an idle arbiter SHALL therefore give dreq at cycle t+2.
REQ-020 SHALL, on dack in BUSY at cycle u, pulse mack[g] at cycle u+1 with mrdata=drdata and merr=derr, then return to IDLE with gnt cleared.
REQ-021 SHALL hold mrdata and merr until the next completion.
REQ-022 SHALL ignore dack in IDLE, or in the same cycle as dreq.
REQ-023 SHALL, when mreq[g] and its grant coincide, issue the old captured fields and leave pend[g] set with the new fields (set beats clear).
REQ-024 SHALL give the next grant no earlier than the cycle after mack (back-to-back throughput of one transfer per dack latency + 2 cycles).

Reset
REQ-025 SHALL force, while rst is high, state=IDLE, pend=0, rrptr=0, gnt=0, mack=0, dreq=0, mrdata=0, merr=0, daddr/dwdata/dwr=0 and the timeout counter to 0.
REQ-026 SHALL drop, when reset occurs mid-transaction, the in-flight transaction silently with no mack, and SHALL ignore a dack arriving after reset.

Configuration
REQ-027 SHALL, with J11_DMA_ARB_TIMEOUT_EN defined, load a counter with TIMEOUT at dreq and decrement it in BUSY; if it reaches 0 without dack, it SHALL pulse mack[g] with merr=1 and mrdata=0 and go to IDLE, and a late dack SHALL be ignored.
REQ-028 SHALL, without J11_DMA_ARB_TIMEOUT_EN, have no counter and wait in BUSY indefinitely.

Structure
REQ-029 SHALL take ADDR_W=18, DATA_W=16 and the state encoding (IDLE/BUSY) from shared package j11_pkg.
REQ-030 SHALL place round-robin selection in combinational sub-module j11_rr_pick (inputs pend and rrptr; outputs valid and one-hot grant).

Verification
REQ-031 SHALL check single request: mreq[1] at t with addr 18'o777000 and read → dreq at t+2 with daddr=18'o777000; dack with drdata=16'o123456 → mack=4'b0010 the next cycle, mrdata=16'o123456, merr=0.
REQ-032 SHALL check fairness: all four requesters pend at once with rrptr=0 → grants in order 0,1,2,3; requester 0 re-requests at once → granted after 3.
REQ-033 SHALL check the error path: derr=1 with dack for a requester-2 write → mack[2]=1 and merr=1.
REQ-034 SHALL check a duplicate request: mreq[0] twice while pend[0] is set with different addresses → only the first address appears on daddr.
REQ-035 SHALL check reset mid-transaction: rst in BUSY, then dack → no mack, gnt=0, pend=0.
REQ-036 SHALL check timeout: with J11_DMA_ARB_TIMEOUT_EN and TIMEOUT=8, no dack → mack at dreq+9 with merr=1 and mrdata=0, and a later dack is ignored.
